cmult_pipe: RTL
===============

# cmult_pipe

Pipelined signed fixed-point complex multiplier for the FFT butterfly datapath. It computes (a_re + j·a_im)·(b_re + j·b_im) on two's-complement Q(WORD_SIZE−FRACTION).FRACTION operands and accepts one operation per cycle. It has a valid/ready handshake with global-stall backpressure, saturation with an overflow flag, and compile-time rounding selection. It sits between the twiddle ROM/data buffer and the butterfly adder stage.

## Interface
- WORD_SIZE, 16, width of every operand and result component (≥ 4)
- FRACTION, 8, number of fractional bits (0 ≤ FRACTION < WORD_SIZE)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input operands valid
- o_ready  out  1  block can accept an input this cycle
- i_a_re, i_a_im  in  WORD_SIZE  operand A, signed
- i_b_re, i_b_im  in  WORD_SIZE  operand B (twiddle), signed
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result this cycle
- o_re, o_im  out  WORD_SIZE  result, signed, saturated
- o_ovf  out  2  {im, re} saturation occurred for the current result

## Operation
- Signed arithmetic throughout. No sign-magnitude conversion is used.
- Stage S1 registers the four operands. It captures on a transfer (i_valid && o_ready).
- Stage S2 registers four products: ar·br, ai·bi, ar·bi, ai·br. Each product is 2·WORD_SIZE bits signed.
- Stage S3 computes re_full = ar·br − ai·bi and im_full = ar·bi + ai·br. Both are 2·WORD_SIZE+1 bits signed.
- Stage S3 then scales each sum, saturates it, and registers it to o_re/o_im/o_ovf.
- Scaling: rounding or truncation per Configuration, then an arithmetic right shift by FRACTION.
- Saturation: if the shifted value > 2^(WORD_SIZE−1)−1, the output clamps to 0x7FFF (for WORD_SIZE 16) and the matching o_ovf bit = 1.
  - If the shifted value < −2^(WORD_SIZE−1), the output clamps to 0x8000 and the matching o_ovf bit = 1.
  - Otherwise the matching o_ovf bit = 0.
- Each stage carries a valid bit: v1, v2, v3, with o_valid = v3.
- Global advance is defined as adv = !v3 || i_ready, and o_ready = adv (combinational).
- When adv = 1:
  - v1 ← i_valid.
  - S2 ← S1 and v2 ← v1.
  - S3 ← S2 and v3 ← v2.
- When adv = 0, every stage register and valid bit holds.
- Data registers of invalid stages may update freely. Only the valid bits are architectural.

## Timing
- Latency: a result appears on o_valid exactly 3 cycles after its accepting edge, provided there is no stall.
- Throughput: 1 operation per cycle while i_ready = 1.
- Ordering: results leave in the order they were accepted. Stalls never drop or duplicate a result.
- Stall: while o_valid && !i_ready, the outputs hold stable and o_ready = 0. At most 3 operations are in flight.
- Simultaneous accept and output in one cycle is legal and sustains full throughput.
- Reset values:
  - v1, v2, v3, o_valid = 0; o_re, o_im = 0; o_ovf = 0.
  - o_ready = 1 immediately after reset is asserted.
- Reset mid-operation: all in-flight operations are discarded with no partial output. The first accept after deassertion has latency 3.

## Configuration
- CMULT_ROUND_EN defined: round-half-up. Before the shift, 2^(FRACTION−1) is added to re_full/im_full. FRACTION = 0 means no addition.
- CMULT_ROUND_EN undefined: truncation, i.e. a plain arithmetic shift (floor toward −∞).
- Saturation and o_ovf are present in both builds.

## Test plan
All values use defaults WORD_SIZE=16, FRACTION=8, in hex.
- Basic: A=(0100,0000), B=(0080,0080), i_ready=1 -> 3 cycles later o_re=0080, o_im=0080, o_ovf=00.
- j·j: A=(0000,0100), B=(0000,0100) -> o_re=FF00, o_im=0000.
- Saturation, positive: A=(7FFF,0000), B=(7FFF,0000) -> o_re=7FFF, o_ovf=01.
- Saturation, min·min: A=(8000,0000), B=(8000,0000) -> o_re=7FFF, o_ovf=01.
- Rounding, A=(0001,0000), B=(0080,0000):
  - With CMULT_ROUND_EN: o_re=0001.
  - Without CMULT_ROUND_EN: o_re=0000.
- Rounding, A=(FFFF,0000), B=(0080,0000):
  - With CMULT_ROUND_EN: o_re=0000.
  - Without CMULT_ROUND_EN: o_re=FFFF.
- Backpressure: hold i_ready=0 and drive 5 back-to-back valid inputs.
  - Exactly 3 are accepted; o_ready=0 from the 4th cycle.
  - Then assert i_ready=1: all 5 results emerge in order with no gaps once flowing.
- Reset mid-flight: assert i_rst with 3 operations in flight.
  - o_valid=0 and outputs=0 immediately.
  - After release, a single new input yields exactly one result 3 cycles later.

Source files
------------

// File: rtl/cmult_pipe.sv
// cmult_pipe: 3-stage pipelined signed fixed-point complex multiplier with saturation.
// Build option: define CMULT_ROUND_EN for round-half-up scaling; otherwise truncation (floor).
module cmult_pipe #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned FRACTION  = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [WORD_SIZE-1:0] i_a_re,
   input  logic [WORD_SIZE-1:0] i_a_im,
   input  logic [WORD_SIZE-1:0] i_b_re,
   input  logic [WORD_SIZE-1:0] i_b_im,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [WORD_SIZE-1:0] o_re,
   output logic [WORD_SIZE-1:0] o_im,
   output logic [1:0]           o_ovf
);

   localparam int unsigned PW = 2 * WORD_SIZE;
   localparam int unsigned SW = PW + 1;
   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};
`ifdef CMULT_ROUND_EN
   localparam logic signed [SW-1:0] RND_C = (FRACTION == 0) ? SW'(0) : SW'(1) << (FRACTION - 1);
`endif

   // Scale a full-precision sum to WORD_SIZE; returns {ovf, value}.
   function automatic logic [WORD_SIZE:0] scale_sat(input logic signed [SW-1:0] full);
      logic signed [SW-1:0] s;
`ifdef CMULT_ROUND_EN
      s = full + RND_C;
`else
      s = full;
`endif
      s = s >>> FRACTION;
      if (s > SAT_MAX)
         scale_sat = {1'b1, 1'b0, {(WORD_SIZE-1){1'b1}}};
      else if (s < SAT_MIN)
         scale_sat = {1'b1, 1'b1, {(WORD_SIZE-1){1'b0}}};
      else
         scale_sat = {1'b0, s[WORD_SIZE-1:0]};
   endfunction

   logic signed [WORD_SIZE-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
   logic signed [PW-1:0]        p_rr_q, p_rr_d, p_ii_q, p_ii_d;
   logic signed [PW-1:0]        p_ri_q, p_ri_d, p_ir_q, p_ir_d;
   logic [WORD_SIZE-1:0]        re_q, re_d, im_q, im_d;
   logic [1:0]                  ovf_q, ovf_d;
   logic                        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic                        adv;
   logic signed [SW-1:0]        re_full, im_full;
   logic [WORD_SIZE:0]          re_sat, im_sat;

   // Global-stall pipeline: every stage moves together when the output slot frees up.
   always_comb begin
      adv    = !v3_q || i_ready;
      ar_d   = ar_q;
      ai_d   = ai_q;
      br_d   = br_q;
      bi_d   = bi_q;
      p_rr_d = p_rr_q;
      p_ii_d = p_ii_q;
      p_ri_d = p_ri_q;
      p_ir_d = p_ir_q;
      re_d   = re_q;
      im_d   = im_q;
      ovf_d  = ovf_q;
      v1_d   = v1_q;
      v2_d   = v2_q;
      v3_d   = v3_q;

      re_full = SW'(p_rr_q) - SW'(p_ii_q);
      im_full = SW'(p_ri_q) + SW'(p_ir_q);
      re_sat  = scale_sat(re_full);
      im_sat  = scale_sat(im_full);

      if (adv) begin
         v1_d = i_valid;
         v2_d = v1_q;
         v3_d = v2_q;
         if (i_valid) begin
            ar_d = i_a_re;
            ai_d = i_a_im;
            br_d = i_b_re;
            bi_d = i_b_im;
         end
         p_rr_d = PW'(ar_q) * PW'(br_q);
         p_ii_d = PW'(ai_q) * PW'(bi_q);
         p_ri_d = PW'(ar_q) * PW'(bi_q);
         p_ir_d = PW'(ai_q) * PW'(br_q);
         re_d   = re_sat[WORD_SIZE-1:0];
         im_d   = im_sat[WORD_SIZE-1:0];
         ovf_d  = {im_sat[WORD_SIZE], re_sat[WORD_SIZE]};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ar_q   <= '0;
         ai_q   <= '0;
         br_q   <= '0;
         bi_q   <= '0;
         p_rr_q <= '0;
         p_ii_q <= '0;
         p_ri_q <= '0;
         p_ir_q <= '0;
         re_q   <= '0;
         im_q   <= '0;
         ovf_q  <= '0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
      end else begin
         ar_q   <= ar_d;
         ai_q   <= ai_d;
         br_q   <= br_d;
         bi_q   <= bi_d;
         p_rr_q <= p_rr_d;
         p_ii_q <= p_ii_d;
         p_ri_q <= p_ri_d;
         p_ir_q <= p_ir_d;
         re_q   <= re_d;
         im_q   <= im_d;
         ovf_q  <= ovf_d;
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
      end
   end

   assign o_ready = adv;
   assign o_valid = v3_q;
   assign o_re    = re_q;
   assign o_im    = im_q;
   assign o_ovf   = ovf_q;

endmodule
